// File: rtl/pin_lock_ctrl.sv
// rtl/pin_lock_ctrl.sv - PIN entry lock: set code twice, unlock by matching code.
// Optional macro PIN_LOCK_LOCKOUT_EN adds fail counting and timed lockout.
module pin_lock_ctrl #(
   parameter int DIGITS = 4,
   parameter int MAX_ATTEMPTS = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   localparam int COUNTER_WIDTH = $clog2(DIGITS + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     key_valid,
   input  logic [3:0]               key_digit,
   output logic                     locked,
   output logic                     error,
   output logic                     lockout,
   output logic [COUNTER_WIDTH-1:0] digits_entered,
   output logic [2:0]               state
);

   localparam int BW = DIGITS * 4;

   typedef enum logic [2:0] {
      SET1         = 3'd0,
      SET2         = 3'd1,
      SET_CHECK    = 3'd2,
      LOCKED       = 3'd3,
      UNLOCK_CHECK = 3'd4,
      LOCKOUT      = 3'd5
   } state_t;

   state_t                   cur, nxt;
   logic [BW-1:0]            entry_q, entry_d, first_q, first_d, code_q, code_d;
   logic [BW-1:0]            shifted;
   logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic                     locked_q, locked_d, error_q, error_d;
   logic                     is_digit, last_digit;

`ifdef PIN_LOCK_LOCKOUT_EN
   localparam int TW = $clog2(LOCKOUT_CYCLES);
   logic [3:0]    fail_q, fail_d, fail_inc;
   logic [TW-1:0] timer_q, timer_d;
`endif

   assign is_digit   = (key_digit <= 4'd9);
   assign last_digit = (cnt_q == COUNTER_WIDTH'(DIGITS - 1));
   assign shifted    = {entry_q[BW-5:0], key_digit};

   always_comb begin
      nxt      = cur;
      entry_d  = entry_q;
      first_d  = first_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      locked_d = locked_q;
      error_d  = 1'b0;
`ifdef PIN_LOCK_LOCKOUT_EN
      fail_d   = fail_q;
      timer_d  = timer_q;
      fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
`endif
      case (cur)
         SET1, SET2, LOCKED: begin
            if (key_valid) begin
               if (is_digit) begin
                  entry_d = shifted;
                  cnt_d   = cnt_q + 1'b1;
                  if (last_digit) begin
                     cnt_d = '0;
                     if (cur == SET1) begin
                        first_d = shifted;
                        entry_d = '0;
                        nxt     = SET2;
                     end else if (cur == SET2) begin
                        nxt = SET_CHECK;
                     end else begin
                        nxt = UNLOCK_CHECK;
                     end
                  end
               end else begin
                  // Clear request: abandon the current entry; a half-done confirm restarts setup.
                  entry_d = '0;
                  cnt_d   = '0;
                  error_d = 1'b1;
                  if (cur == SET2) nxt = SET1;
               end
            end
         end
         SET_CHECK: begin
            cnt_d   = '0;
            entry_d = '0;
            if (entry_q == first_q) begin
               code_d   = entry_q;
               locked_d = 1'b1;
               nxt      = LOCKED;
            end else begin
               error_d = 1'b1;
               nxt     = SET1;
            end
         end
         UNLOCK_CHECK: begin
            cnt_d   = '0;
            entry_d = '0;
            if (entry_q == code_q) begin
               locked_d = 1'b0;
`ifdef PIN_LOCK_LOCKOUT_EN
               fail_d   = '0;
`endif
               nxt      = SET1;
            end else begin
               error_d = 1'b1;
               nxt     = LOCKED;
`ifdef PIN_LOCK_LOCKOUT_EN
               fail_d  = fail_inc;
               if (fail_inc == 4'(MAX_ATTEMPTS)) begin
                  timer_d = '0;
                  nxt     = LOCKOUT;
               end
`endif
            end
         end
         LOCKOUT: begin
            cnt_d = '0;
`ifdef PIN_LOCK_LOCKOUT_EN
            locked_d = 1'b1;
            if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
               timer_d = '0;
               fail_d  = '0;
               nxt     = LOCKED;
            end else begin
               timer_d = timer_q + 1'b1;
            end
`else
            nxt = LOCKED;
`endif
         end
         default: begin
            cnt_d   = '0;
            entry_d = '0;
            nxt     = SET1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur      <= SET1;
         entry_q  <= '0;
         first_q  <= '0;
         code_q   <= '0;
         cnt_q    <= '0;
         locked_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         cur      <= nxt;
         entry_q  <= entry_d;
         first_q  <= first_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
         error_q  <= error_d;
      end
   end

`ifdef PIN_LOCK_LOCKOUT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fail_q  <= '0;
         timer_q <= '0;
      end else begin
         fail_q  <= fail_d;
         timer_q <= timer_d;
      end
   end

   assign lockout = (cur == LOCKOUT);
`else
   assign lockout = 1'b0;
`endif

   assign locked         = locked_q;
   assign error          = error_q;
   assign digits_entered = cnt_q;
   assign state          = cur;

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// tb/tb_pin_lock_ctrl.sv - table-driven scoreboard bench for pin_lock_ctrl.
// Expectations follow PIN_LOCK_LOCKOUT_EN when defined for the build.
module tb_pin_lock_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_digit = 4'd0;
   logic       locked, error, lockout;
   logic [2:0] digits_entered;
   logic [2:0] state;

   always #5 clock = ~clock;

   pin_lock_ctrl #(.DIGITS(4), .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(8)) dut (
      .clock(clock),
      .reset(reset),
      .key_valid(key_valid),
      .key_digit(key_digit),
      .locked(locked),
      .error(error),
      .lockout(lockout),
      .digits_entered(digits_entered),
      .state(state)
   );

   typedef struct {
      logic       kv;
      logic [3:0] kd;
      logic [2:0] st;
      logic       lk;
      logic       er;
      logic       lo;
      logic [2:0] cnt;
   } vec_t;

   typedef struct packed {
      logic [2:0] st;
      logic       lk;
      logic       er;
      logic       lo;
      logic [2:0] cnt;
   } obs_t;

   vec_t tbl[$];
   obs_t exp_q[$];
   int   passed = 0;
   int   total = 0;
   int   vec_idx = 0;

   function automatic obs_t observe();
      return '{state, locked, error, lockout, digits_entered};
   endfunction

   task automatic chk(input string name, input int idx, input obs_t act, input obs_t exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s[%0d]: got st=%0d lk=%b er=%b lo=%b cnt=%0d, expected st=%0d lk=%b er=%b lo=%b cnt=%0d",
                    name, idx, act.st, act.lk, act.er, act.lo, act.cnt,
                    exp.st, exp.lk, exp.er, exp.lo, exp.cnt);
   endtask

   task automatic add(input logic kv, input logic [3:0] kd, input logic [2:0] st,
                      input logic lk, input logic er, input logic lo, input logic [2:0] cnt);
      tbl.push_back('{kv, kd, st, lk, er, lo, cnt});
   endtask

   task automatic add_code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [2:0] s_mid,
                           input logic [2:0] s_last, input logic lk);
      logic [3:0] ds[4];
      ds = '{a, b, c, d};
      for (int i = 0; i < 3; i++) add(1'b1, ds[i], s_mid, lk, 1'b0, 1'b0, 3'(i + 1));
      add(1'b1, ds[3], s_last, lk, 1'b0, 1'b0, 3'd0);
   endtask

   task automatic run_table(input string name);
      obs_t e;
      for (int i = 0; i < tbl.size(); i++) begin
         key_valid = tbl[i].kv;
         key_digit = tbl[i].kd;
         exp_q.push_back('{tbl[i].st, tbl[i].lk, tbl[i].er, tbl[i].lo, tbl[i].cnt});
         @(posedge clock);
         #1;
         key_valid = 1'b0;
         key_digit = 4'd0;
         e = exp_q.pop_front();
         chk(name, vec_idx, observe(), e);
         vec_idx++;
      end
      tbl.delete();
   endtask

   initial begin
      obs_t zero;
      zero = '{3'd0, 1'b0, 1'b0, 1'b0, 3'd0};

      repeat (2) @(posedge clock);
      #1;
      chk("reset", 0, observe(), zero);
      reset = 1'b1;

      // set, confirm, lock, unlock
      add_code(1, 2, 3, 4, 3'd0, 3'd1, 1'b0);
      add_code(1, 2, 3, 4, 3'd1, 3'd2, 1'b0);
      add(0, 0, 3'd3, 1, 0, 0, 3'd0);
      add_code(1, 2, 3, 4, 3'd3, 3'd4, 1'b1);
      add(0, 0, 3'd0, 0, 0, 0, 3'd0);
      // confirm mismatch
      add_code(1, 2, 3, 4, 3'd0, 3'd1, 1'b0);
      add_code(1, 2, 3, 5, 3'd1, 3'd2, 1'b0);
      add(0, 0, 3'd0, 0, 1, 0, 3'd0);
      add(0, 0, 3'd0, 0, 0, 0, 3'd0);
      // clear requests in SET1 and SET2
      add(1, 1, 3'd0, 0, 0, 0, 3'd1);
      add(1, 2, 3'd0, 0, 0, 0, 3'd2);
      add(1, 12, 3'd0, 0, 1, 0, 3'd0);
      add_code(3, 4, 5, 6, 3'd0, 3'd1, 1'b0);
      add(1, 15, 3'd0, 0, 1, 0, 3'd0);
      // keys ignored in check states; a good unlock clears the fail count
      add_code(5, 6, 7, 8, 3'd0, 3'd1, 1'b0);
      add_code(5, 6, 7, 8, 3'd1, 3'd2, 1'b0);
      add(1, 1, 3'd3, 1, 0, 0, 3'd0);
      add_code(5, 6, 7, 9, 3'd3, 3'd4, 1'b1);
      add(1, 1, 3'd3, 1, 1, 0, 3'd0);
      add_code(5, 6, 7, 8, 3'd3, 3'd4, 1'b1);
      add(0, 0, 3'd0, 0, 0, 0, 3'd0);
      add_code(5, 6, 7, 8, 3'd0, 3'd1, 1'b0);
      add_code(5, 6, 7, 8, 3'd1, 3'd2, 1'b0);
      add(0, 0, 3'd3, 1, 0, 0, 3'd0);
`ifdef PIN_LOCK_LOCKOUT_EN
      for (int k = 0; k < 3; k++) begin
         add_code(9, 9, 9, 9, 3'd3, 3'd4, 1'b1);
         add(0, 0, (k == 2) ? 3'd5 : 3'd3, 1, 1, (k == 2), 3'd0);
      end
      for (int j = 0; j < 7; j++) add(1, 1, 3'd5, 1, 0, 1, 3'd0);
      add(0, 0, 3'd3, 1, 0, 0, 3'd0);
      for (int k = 0; k < 2; k++) begin
         add_code(9, 9, 9, 9, 3'd3, 3'd4, 1'b1);
         add(0, 0, 3'd3, 1, 1, 0, 3'd0);
      end
`else
      for (int k = 0; k < 10; k++) begin
         add_code(9, 9, 9, 9, 3'd3, 3'd4, 1'b1);
         add(0, 0, 3'd3, 1, 1, 0, 3'd0);
      end
`endif
      add_code(5, 6, 7, 8, 3'd3, 3'd4, 1'b1);
      add(0, 0, 3'd0, 0, 0, 0, 3'd0);
      run_table("vec");

      // reset asserted four cycles into lockout (or while locked without the feature)
      add_code(1, 2, 3, 4, 3'd0, 3'd1, 1'b0);
      add_code(1, 2, 3, 4, 3'd1, 3'd2, 1'b0);
      add(0, 0, 3'd3, 1, 0, 0, 3'd0);
`ifdef PIN_LOCK_LOCKOUT_EN
      for (int k = 0; k < 3; k++) begin
         add_code(9, 9, 9, 9, 3'd3, 3'd4, 1'b1);
         add(0, 0, (k == 2) ? 3'd5 : 3'd3, 1, 1, (k == 2), 3'd0);
      end
      for (int j = 0; j < 3; j++) add(1, 1, 3'd5, 1, 0, 1, 3'd0);
`else
      for (int k = 0; k < 3; k++) begin
         add_code(9, 9, 9, 9, 3'd3, 3'd4, 1'b1);
         add(0, 0, 3'd3, 1, 1, 0, 3'd0);
      end
      add(1, 1, 3'd3, 1, 0, 0, 3'd1);
`endif
      run_table("pre_rst");

      #2;
      reset = 1'b0;
      #1;
      chk("rst_async", 0, observe(), zero);
      @(posedge clock);
      #1;
      chk("rst_hold", 0, observe(), zero);
      reset = 1'b1;
      add(1, 7, 3'd0, 0, 0, 0, 3'd1);
      add(1, 8, 3'd0, 0, 0, 0, 3'd2);
      run_table("post_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
